// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t    : FSM state encoding, also driven out on the state port.
//   LOSS_CNT_W : width of the saturating lock-loss counter.
//   cnt_w()    : bits needed for a counter that holds the values 0..n-1.
//                It is used to size the prescaler, stage, debounce and index counters.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // The result is never below 1 bit, so counters with n of 1 or 2 still get a legal width.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; clears the whole chain to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output, delayed by STAGES clk edges
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on and manual reset generator with staged per-domain release.
//   clk           : system clock (PLL output domain)
//   rst           : asynchronous active-low block reset
//   manual        : asynchronous active-high manual reset request (button)
//   pll_locked    : asynchronous PLL lock indicator
//   rst_out       : active-high per-domain resets, registered; channel 0 is released first
//   done          : high once every channel has been released (RUN)
//   state         : current FSM state (HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3)
//   lock_loss_cnt : saturating count of lock losses seen in RELEASE or RUN
//
// Handshake: none. All inputs are levels. The outputs are registered levels that
// downstream logic may sample on any clk edge.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int PRESCALE       = 1000,
    parameter int STAGE_TICKS    = 4,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  manual,
    input  logic                  pll_locked,
    output logic [N_CH-1:0]       rst_out,
    output logic                  done,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int PRESC_W = cnt_w(PRESCALE);
    localparam int STAGE_W = cnt_w(STAGE_TICKS);
    localparam int DEB_W   = cnt_w(DEBOUNCE_TICKS);
    localparam int IDX_W   = cnt_w(N_CH);

    logic manual_s;
    logic locked_s;
    logic tick;

    state_t                  state_q, state_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [DEB_W-1:0]        deb_q, deb_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_CH-1:0]         rst_out_q, rst_out_d;
    logic                    done_q, done_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_manual (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (manual),
        .q_o    (manual_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    assign tick = (presc_q == PRESC_W'(PRESCALE - 1));

    always_comb begin
        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        stage_d   = stage_q;
        deb_d     = deb_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        loss_d    = loss_q;

        if (manual_s) begin
            // A manual request outranks everything, including a simultaneous lock loss.
            state_d   = HOLD;
            rst_out_d = '1;
            done_d    = 1'b0;
            deb_d     = '0;
            idx_d     = '0;
        end else if (((state_q == RELEASE) || (state_q == RUN)) && !locked_s) begin
            state_d   = WAIT_LOCK;
            rst_out_d = '1;
            done_d    = 1'b0;
            idx_d     = '0;
            if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                loss_d = loss_q + 1'b1;
            end
        end else begin
            case (state_q)
                HOLD: begin
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    if (tick) begin
                        if (deb_q == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                            state_d = WAIT_LOCK;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end
                end
                WAIT_LOCK: begin
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    if (locked_s) begin
                        state_d = RELEASE;
                        idx_d   = '0;
                    end
                end
                RELEASE: begin
                    // The stage counter wraps between channels. This keeps the release
                    // spacing at exactly STAGE_TICKS ticks without clearing the prescaler.
                    if (tick) begin
                        if (stage_q == STAGE_W'(STAGE_TICKS - 1)) begin
                            stage_d = '0;
                            for (int k = 0; k < N_CH; k++) begin
                                if (k == int'(idx_q)) begin
                                    rst_out_d[k] = 1'b0;
                                end
                            end
                            if (idx_q == IDX_W'(N_CH - 1)) begin
                                state_d = RUN;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end

        // Every state starts its own timing from zero.
        if (state_d != state_q) begin
            presc_d = '0;
            stage_d = '0;
            deb_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HOLD;
            presc_q   <= '0;
            stage_q   <= '0;
            deb_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            stage_q   <= stage_d;
            deb_q     <= deb_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            loss_q    <= loss_d;
        end
    end

    assign rst_out       = rst_out_q;
    assign done          = done_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int N_CH           = 3;
    localparam int PRESCALE       = 4;
    localparam int STAGE_TICKS    = 2;
    localparam int DEBOUNCE_TICKS = 2;
    localparam int SYNC_STAGES    = 2;

    localparam int STAGE_CYC = STAGE_TICKS * PRESCALE;
    localparam int SEQ_CYC   = N_CH * STAGE_CYC;
    localparam int DEB_CYC   = DEBOUNCE_TICKS * PRESCALE;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [N_CH-1:0] ALL_ON = {N_CH{1'b1}};

    logic            clk;
    logic            rst;
    logic            manual;
    logic            pll_locked;
    logic [N_CH-1:0] rst_out;
    logic            done;
    logic [1:0]      state;
    logic [7:0]      lock_loss_cnt;

    int n_checks;
    int n_pass;
    int exp_loss;

    reset_sequencer #(
        .N_CH           (N_CH),
        .PRESCALE       (PRESCALE),
        .STAGE_TICKS    (STAGE_TICKS),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .manual        (manual),
        .pll_locked    (pll_locked),
        .rst_out       (rst_out),
        .done          (done),
        .state         (state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Channel k is low from cycle (k+1)*STAGE_TICKS*PRESCALE after RELEASE entry.
    function automatic logic [N_CH-1:0] exp_rst_at(input int c);
        logic [N_CH-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k] = (c < (k + 1) * STAGE_CYC);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget,
                              output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        forever begin
            if (state === target) begin
                found = 1'b1;
                break;
            end
            if (cycles >= budget) break;
            step();
            cycles++;
        end
    endtask

    task automatic apply_reset(input logic lock);
        rst = 1'b0;
        manual = 1'b0;
        pll_locked = lock;
        repeat (5) step();
        n_checks++;
        if ({rst_out, done, state, lock_loss_cnt} !== {ALL_ON, 1'b0, S_HOLD, 8'd0})
            $display("FAIL reset_values: got rst_out=%b done=%b state=%0d cnt=%0d expected %b 0 0 0",
                     rst_out, done, state, lock_loss_cnt, ALL_ON);
        else n_pass++;
        rst = 1'b1;
        exp_loss = 0;
    endtask

    // Called on the first RELEASE cycle; walks the entire release sequence.
    task automatic check_release_sequence(input string tag);
        for (int c = 0; c <= SEQ_CYC + 3; c++) begin
            logic [N_CH-1:0] er;
            logic            ed;
            logic [1:0]      es;
            er = exp_rst_at(c);
            ed = (c >= SEQ_CYC);
            es = ed ? S_RUN : S_REL;
            n_checks++;
            if (rst_out !== er)
                $display("FAIL %s rst_out cycle %0d: got %b expected %b", tag, c, rst_out, er);
            else n_pass++;
            n_checks++;
            if (done !== ed)
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, c, done, ed);
            else n_pass++;
            n_checks++;
            if (state !== es)
                $display("FAIL %s state cycle %0d: got %0d expected %0d", tag, c, state, es);
            else n_pass++;
            step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cyc;
        bit ok;
        apply_reset(1'b1);
        wait_state(S_WAIT, 20, cyc, ok);
        n_checks++;
        if (!ok || cyc != DEB_CYC)
            $display("FAIL pu_hold_to_wait: found=%0d cycles=%0d expected cycles=%0d", ok, cyc, DEB_CYC);
        else n_pass++;
        wait_state(S_REL, 5, cyc, ok);
        n_checks++;
        if (!ok || cyc != 1)
            $display("FAIL pu_wait_to_release: found=%0d cycles=%0d expected 1", ok, cyc);
        else n_pass++;
        check_release_sequence("power_up");
    endtask

    task automatic test_lock_gating();
        int cyc;
        bit ok;
        int hold;
        apply_reset(1'b0);
        wait_state(S_WAIT, 20, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL gate_reach_wait: state=%0d expected %0d", state, S_WAIT);
        else n_pass++;
        hold = 100 + int'($urandom_range(0, 20));
        for (int i = 0; i < hold; i++) begin
            step();
            n_checks++;
            if ({state, rst_out} !== {S_WAIT, ALL_ON})
                $display("FAIL gate_hold cycle %0d: got state=%0d rst_out=%b expected %0d %b",
                         i, state, rst_out, S_WAIT, ALL_ON);
            else n_pass++;
        end
        pll_locked = 1'b1;
        wait_state(S_REL, SYNC_STAGES + 3, cyc, ok);
        n_checks++;
        if (!ok || cyc != SYNC_STAGES + 1)
            $display("FAIL gate_release_latency: found=%0d cycles=%0d expected %0d", ok, cyc, SYNC_STAGES + 1);
        else n_pass++;
        check_release_sequence("lock_gate");
    endtask

    task automatic test_manual_mid_release();
        int cyc;
        bit ok;
        int extra;
        apply_reset(1'b1);
        wait_state(S_REL, DEB_CYC + 10, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL man_reach_release: state=%0d expected %0d", state, S_REL);
        else n_pass++;
        extra = int'($urandom_range(0, STAGE_CYC - SYNC_STAGES - 2));
        repeat (STAGE_CYC + extra) step();
        n_checks++;
        if (rst_out !== exp_rst_at(STAGE_CYC + extra))
            $display("FAIL man_pre_state: got rst_out=%b expected %b", rst_out, exp_rst_at(STAGE_CYC + extra));
        else n_pass++;
        manual = 1'b1;
        wait_state(S_HOLD, SYNC_STAGES + 1, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL man_to_hold: state=%0d expected %0d after %0d cycles", state, S_HOLD, cyc);
        else n_pass++;
        n_checks++;
        if ({rst_out, done, lock_loss_cnt} !== {ALL_ON, 1'b0, 8'(exp_loss)})
            $display("FAIL man_hold_outputs: got rst_out=%b done=%b cnt=%0d expected %b 0 %0d",
                     rst_out, done, lock_loss_cnt, ALL_ON, exp_loss);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({state, rst_out} !== {S_HOLD, ALL_ON})
                $display("FAIL man_held cycle %0d: state=%0d rst_out=%b expected %0d %b", i, state, rst_out, S_HOLD, ALL_ON);
            else n_pass++;
        end
        manual = 1'b0;
        repeat (3) step();
        manual = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks++;
            if (state !== S_HOLD)
                $display("FAIL man_glitch cycle %0d: state=%0d expected %0d", i, state, S_HOLD);
            else n_pass++;
        end
        manual = 1'b0;
        wait_state(S_WAIT, DEB_CYC + PRESCALE + 8, cyc, ok);
        n_checks++;
        if (!ok || cyc < DEB_CYC - PRESCALE || cyc > DEB_CYC + PRESCALE)
            $display("FAIL man_debounce: found=%0d cycles=%0d expected %0d..%0d",
                     ok, cyc, DEB_CYC - PRESCALE, DEB_CYC + PRESCALE);
        else n_pass++;
        wait_state(S_REL, 5, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL man_rerelease: state=%0d expected %0d", state, S_REL);
        else n_pass++;
        check_release_sequence("after_manual");
    endtask

    task automatic test_priority();
        int cyc;
        bit ok;
        apply_reset(1'b1);
        wait_state(S_RUN, DEB_CYC + SEQ_CYC + 10, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL prio_reach_run: state=%0d expected %0d", state, S_RUN);
        else n_pass++;
        repeat ($urandom_range(0, 5)) step();
        manual = 1'b1;
        pll_locked = 1'b0;
        wait_state(S_HOLD, SYNC_STAGES + 1, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL prio_to_hold: state=%0d expected %0d", state, S_HOLD);
        else n_pass++;
        n_checks++;
        if ({rst_out, done, lock_loss_cnt} !== {ALL_ON, 1'b0, 8'(exp_loss)})
            $display("FAIL prio_outputs: got rst_out=%b done=%b cnt=%0d expected %b 0 %0d",
                     rst_out, done, lock_loss_cnt, ALL_ON, exp_loss);
        else n_pass++;
        repeat (10) step();
        manual = 1'b0;
        wait_state(S_WAIT, DEB_CYC + PRESCALE + 8, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL prio_to_wait: state=%0d expected %0d", state, S_WAIT);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({state, lock_loss_cnt} !== {S_WAIT, 8'(exp_loss)})
                $display("FAIL prio_wait_nolock cycle %0d: state=%0d cnt=%0d expected %0d %0d",
                         i, state, lock_loss_cnt, S_WAIT, exp_loss);
            else n_pass++;
        end
        pll_locked = 1'b1;
        wait_state(S_RUN, SEQ_CYC + SYNC_STAGES + 6, cyc, ok);
        n_checks++;
        if (!ok || lock_loss_cnt !== 8'(exp_loss))
            $display("FAIL prio_rerun: found=%0d cnt=%0d expected cnt %0d", ok, lock_loss_cnt, exp_loss);
        else n_pass++;
    endtask

    task automatic lock_pulse();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
    endtask

    task automatic test_lock_loss();
        int cyc;
        bit ok;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) step();
            lock_pulse();
            wait_state(S_WAIT, SYNC_STAGES, cyc, ok);
            n_checks++;
            if (!ok) $display("FAIL loss_to_wait iter %0d: state=%0d expected %0d", i, state, S_WAIT);
            else n_pass++;
            n_checks++;
            if ({rst_out, done, lock_loss_cnt} !== {ALL_ON, 1'b0, 8'(exp_loss)})
                $display("FAIL loss_outputs iter %0d: got rst_out=%b done=%b cnt=%0d expected %b 0 %0d",
                         i, rst_out, done, lock_loss_cnt, ALL_ON, exp_loss);
            else n_pass++;
            wait_state(S_REL, 4, cyc, ok);
            n_checks++;
            if (!ok) $display("FAIL loss_rerelease iter %0d: state=%0d expected %0d", i, state, S_REL);
            else n_pass++;
            if (i < 2) begin
                check_release_sequence("lock_loss");
            end else begin
                wait_state(S_RUN, SEQ_CYC + 2, cyc, ok);
                n_checks++;
                if (!ok || cyc != SEQ_CYC)
                    $display("FAIL loss_rerun iter %0d: found=%0d cycles=%0d expected %0d", i, ok, cyc, SEQ_CYC);
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd255)
            $display("FAIL loss_saturate: got %0d expected 255", lock_loss_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        lock_pulse();
        wait_state(S_WAIT, SYNC_STAGES, cyc, ok);
        wait_state(S_REL, 4, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL async_reach_release: state=%0d expected %0d", state, S_REL);
        else n_pass++;
        repeat (STAGE_CYC + 2) step();
        n_checks++;
        if ({rst_out, lock_loss_cnt} !== {exp_rst_at(STAGE_CYC + 2), 8'(exp_loss)})
            $display("FAIL async_pre: got rst_out=%b cnt=%0d expected %b %0d",
                     rst_out, lock_loss_cnt, exp_rst_at(STAGE_CYC + 2), exp_loss);
        else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rst_out, done, state, lock_loss_cnt} !== {ALL_ON, 1'b0, S_HOLD, 8'd0})
            $display("FAIL async_immediate: got rst_out=%b done=%b state=%0d cnt=%0d expected %b 0 0 0",
                     rst_out, done, state, lock_loss_cnt, ALL_ON);
        else n_pass++;
        step();
        n_checks++;
        if ({rst_out, done, state, lock_loss_cnt} !== {ALL_ON, 1'b0, S_HOLD, 8'd0})
            $display("FAIL async_held: got rst_out=%b done=%b state=%0d cnt=%0d expected %b 0 0 0",
                     rst_out, done, state, lock_loss_cnt, ALL_ON);
        else n_pass++;
        rst = 1'b1;
        exp_loss = 0;
        wait_state(S_WAIT, DEB_CYC + 2, cyc, ok);
        n_checks++;
        if (!ok || cyc != DEB_CYC)
            $display("FAIL async_hold_to_wait: found=%0d cycles=%0d expected %0d", ok, cyc, DEB_CYC);
        else n_pass++;
        wait_state(S_REL, 5, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL async_rerelease: state=%0d expected %0d", state, S_REL);
        else n_pass++;
        check_release_sequence("after_async");
        n_checks++;
        if (lock_loss_cnt !== 8'(exp_loss))
            $display("FAIL async_cnt: got %0d expected %0d", lock_loss_cnt, exp_loss);
        else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        exp_loss   = 0;
        rst        = 1'b0;
        manual     = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_lock_gating();
        test_manual_mid_release();
        test_priority();
        test_lock_loss();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and manual reset generator for the ECP5 top level, replacing the fixed 3-bit startup counter.
- Holds N_CH downstream reset domains in reset until the PLL reports lock and the manual reset input is released and debounced.
- Releases the domains one at a time, channel 0 first, at a fixed tick spacing.
- Re-asserts every domain on lock loss or manual reset, and counts lock-loss events.

Parameters:
N_CH, 3, number of reset domains (1..8)
PRESCALE, 1000, clk cycles per internal tick (>=2)
STAGE_TICKS, 4, ticks between consecutive channel releases (>=1)
DEBOUNCE_TICKS, 8, consecutive low ticks of manual required before leaving HOLD (>=1)
SYNC_STAGES, 2, synchroniser depth for manual and pll_locked (>=2)

Ports:
clk  in  1  system clock (PLL output domain)
rst  in  1  asynchronous, active-low block reset
manual  in  1  async active-high manual reset request (button)
pll_locked  in  1  async PLL lock indicator
rst_out  out  N_CH  active-high per-domain resets, registered
done  out  1  high when all channels are released (RUN)
state  out  2  current FSM state encoding
lock_loss_cnt  out  8  saturating count of lock-loss events

Behaviour:
- rst low (async): rst_out = all 1s, done = 0, state = HOLD, lock_loss_cnt = 0, all counters and synchronisers = 0.
- manual and pll_locked each pass through SYNC_STAGES flops before use (manual_s, locked_s).
- Prescaler counts 0..PRESCALE-1 and asserts tick on the cycle its value is PRESCALE-1.
  - Prescaler and tick counter clear on every state change, so stage durations are exact.
- State encodings: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- HOLD:
  - rst_out = all 1s.
  - Debounce counter increments on each tick while manual_s=0 and clears whenever manual_s=1.
  - When the count reaches DEBOUNCE_TICKS -> WAIT_LOCK.
- WAIT_LOCK:
  - rst_out = all 1s.
  - locked_s=1 -> RELEASE, with channel index = 0.
- RELEASE:
  - Channel k goes low exactly (k+1)*STAGE_TICKS*PRESCALE cycles after the first RELEASE cycle.
  - Released channels stay low; unreleased channels stay high.
  - The cycle the last channel goes low, state -> RUN and done -> 1.
- RUN: hold outputs; done = 1.
- Priority, evaluated every cycle in any state:
  1. manual_s=1 -> HOLD next cycle; rst_out all 1s and done 0 on that same edge.
  2. Otherwise, in RELEASE or RUN, locked_s=0 -> WAIT_LOCK; rst_out all 1s and done 0 on that edge. lock_loss_cnt increments, saturating at 255.
- Lock loss in HOLD or WAIT_LOCK is not counted.
- Manual pulses shorter than one clk may be missed; the design does not require capturing them.
- N_CH=1: a single stage, then RUN.
- The channel index never exceeds N_CH-1.
- lock_loss_cnt is cleared only by rst.

Decomposition:
- Package reset_seq_pkg:
  - state_t enum (HOLD, WAIT_LOCK, RELEASE, RUN; 2 bits).
  - Localparam widths derived via $clog2 for the prescaler, stage, debounce and index counters.
  - LOSS_CNT_W = 8.
- Sub-module bit_sync: a SYNC_STAGES-deep flop chain with async active-low reset to 0, instantiated twice.

Test Plan:
Common bench parameters: N_CH=3, PRESCALE=4, STAGE_TICKS=2, DEBOUNCE_TICKS=2, SYNC_STAGES=2. Cycle 0 = first RELEASE cycle.
1. Power-up: rst low 5 cycles, then high; manual=0, pll_locked=1 -> state passes HOLD -> WAIT_LOCK -> RELEASE; rst_out[0] falls at cycle 8, rst_out[1] at 16, rst_out[2] at 24; done=1 at 24; rst_out=3'b000 afterwards.
2. Lock gating: pll_locked=0 at power-up -> stays in WAIT_LOCK with rst_out=3'b111 for 100 cycles; raise lock -> release sequence as in test 1, relative to RELEASE entry.
3. Lock loss: in RUN, drop pll_locked for 1 cycle -> rst_out=3'b111 and done=0 within SYNC_STAGES+1 cycles; lock_loss_cnt=1; full re-sequence follows. Repeat 300 times -> lock_loss_cnt saturates at 255.
4. Manual reset mid-RELEASE: assert manual after rst_out[0] is released -> rst_out=3'b111 and state=HOLD within SYNC_STAGES+1 cycles. Hold manual high 20 cycles; glitch it low for 3 cycles, then high again -> remains in HOLD. Release manual -> WAIT_LOCK after 2 ticks (8 cycles ±PRESCALE).
5. Priority: manual and lock loss in the same cycle during RUN -> state=HOLD and lock_loss_cnt unchanged.
6. Async reset during RELEASE: pulse rst low for 1 cycle -> all outputs return to reset values immediately, without waiting for a clk edge.
